piece_cell_checker: RTL and testbench

Consumes the four block coordinates produced for the active tetromino and resolves them against the playfield occupancy RAM. In CHECK mode it reads the four cells and reports whether the candidate placement collides with a wall, the floor, or a settled block. In LOCK mode it writes the four cells as occupied. It sits between the game-control FSM (move/rotate/drop decisions) and the single-port board RAM.

---
 rtl/tetris_pkg.sv | 31 +++
 rtl/cell_addr.sv | 32 +++
 rtl/piece_cell_checker.sv | 131 +++++++++++++
 tb/tb_piece_cell_checker.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, op encoding and checker state for the tetromino
// placement logic.
package tetris_pkg;

    localparam int COLS_DEF   = 10;
    localparam int ROWS_DEF   = 20;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic {
        OP_CHECK = 1'b0,
        OP_LOCK  = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_e;

    function automatic logic blk_oob(
        input logic [3:0] x,
        input logic [4:0] y,
        input int         cols,
        input int         rows
    );
        return (int'(x) >= cols) || (int'(y) >= rows);
    endfunction

endpackage

// File: rtl/cell_addr.sv
// Maps one block coordinate to its board RAM address and flags cells that
// fall outside the playfield.
module cell_addr
    import tetris_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [3:0]        x_i,
    input  logic [4:0]        y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              oob_o
);

    logic [ADDR_W-1:0] xe;
    logic [ADDR_W-1:0] ye;

    assign xe = ADDR_W'(x_i);
    assign ye = ADDR_W'(y_i);

    generate
        if (COLS == 10) begin : g_ten
            assign addr_o = (ye << 3) + (ye << 1) + xe;
        end else begin : g_gen
            assign addr_o = ye * ADDR_W'(COLS) + xe;
        end
    endgenerate

    assign oob_o = blk_oob(x_i, y_i, COLS, ROWS);

endmodule

// File: rtl/piece_cell_checker.sv
// Resolves the four cells of the active piece against the board RAM:
// CHECK reads them for collisions, LOCK marks them occupied.
module piece_cell_checker
    import tetris_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              op,
    input  logic [3:0]        x1,
    input  logic [3:0]        x2,
    input  logic [3:0]        x3,
    input  logic [3:0]        x4,
    input  logic [4:0]        y1,
    input  logic [4:0]        y2,
    input  logic [4:0]        y3,
    input  logic [4:0]        y4,
    output logic              busy,
    output logic              done,
    output logic              collide,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic              ram_rdata,
    output logic              ram_we,
    output logic              ram_wdata
);

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic            acc_q, acc_d;
    logic [3:0][3:0] xs_q, xs_d;
    logic [3:0][4:0] ys_q, ys_d;

    logic              oob_in;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oob;

    assign oob_in = blk_oob(x1, y1, COLS, ROWS) | blk_oob(x2, y2, COLS, ROWS)
                  | blk_oob(x3, y3, COLS, ROWS) | blk_oob(x4, y4, COLS, ROWS);

    cell_addr #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .x_i    (xs_q[idx_q]),
        .y_i    (ys_q[idx_q]),
        .addr_o (sel_addr),
        .oob_o  (sel_oob)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            xs_q    <= '0;
            ys_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        xs_d      = xs_q;
        ys_d      = ys_q;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = 1'b0;
        ram_addr  = '0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    xs_d  = {x4, x3, x2, x1};
                    ys_d  = {y4, y3, y2, y1};
                    idx_d = '0;
                    acc_d = oob_in;
                    if (oob_in)
                        state_d = ST_DONE;
                    else if (op_e'(op) == OP_LOCK)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Never strobe a cell that is not on the board.
                ram_re   = !sel_oob;
                ram_addr = sel_oob ? '0 : sel_addr;
                if (idx_q != 2'd0)
                    acc_d = acc_q | ram_rdata;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                acc_d   = acc_q | ram_rdata;
                state_d = ST_DONE;
            end
            ST_WRITE: begin
                ram_we    = !sel_oob;
                ram_wdata = !sel_oob;
                ram_addr  = sel_oob ? '0 : sel_addr;
                idx_d     = idx_q + 2'd1;
                if (idx_q == 2'd3)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign collide = acc_q;

endmodule

// File: tb/tb_piece_cell_checker.sv
// Randomized bench for piece_cell_checker with a board RAM model and an
// independent placement reference model.
module tb_piece_cell_checker;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       op;
    logic [3:0] x1, x2, x3, x4;
    logic [4:0] y1, y2, y3, y4;
    logic       busy, done, collide;
    logic [7:0] ram_addr;
    logic       ram_re, ram_we, ram_wdata;
    logic       rdata_q;

    bit ram[256];
    bit ref_board[256];
    int n_chk;
    int n_fail;
    int bad_cnt;
    int wr_nonzero;

    piece_cell_checker dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y4        (y4),
        .busy      (busy),
        .done      (done),
        .collide   (collide),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_rdata (rdata_q),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetn) begin
            if (ram_we) begin
                ram[ram_addr] <= ram_wdata;
                if (ram_addr != 8'd0)
                    wr_nonzero <= wr_nonzero + 1;
            end
            rdata_q <= ram_re ? ram[ram_addr] : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (ram_re && ram_we)
                bad_cnt <= bad_cnt + 1;
            if (!ram_re && !ram_we && ram_addr != 8'd0)
                bad_cnt <= bad_cnt + 1;
            if (ram_we && !ram_wdata)
                bad_cnt <= bad_cnt + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_boards();
        for (int i = 0; i < 256; i++) begin
            ram[i]       = 1'b0;
            ref_board[i] = 1'b0;
        end
    endtask

    task automatic run_op(
        input bit              opv,
        input logic [3:0][3:0] xv,
        input logic [3:0][4:0] yv,
        input bit              dup
    );
        bit oob;
        bit exp_col;
        int exp_lat;
        int addrs[4];
        int done_cnt;
        int done_at;
        bit col_at_done;
        bit busy_at_done;
        int acc_addr[$];
        int acc_cyc[$];
        bit acc_we[$];
        oob = 0;
        exp_col = 0;
        done_cnt = 0;
        done_at = 0;
        col_at_done = 0;
        busy_at_done = 0;
        for (int i = 0; i < 4; i++) begin
            addrs[i] = int'(yv[i]) * 10 + int'(xv[i]);
            if (xv[i] >= 10 || yv[i] >= 20)
                oob = 1;
        end
        if (oob)
            exp_col = 1;
        else if (!opv)
            for (int i = 0; i < 4; i++)
                exp_col |= ref_board[addrs[i]];
        exp_lat = oob ? 1 : (opv ? 5 : 6);

        @(negedge clk);
        start = 1'b1;
        op = opv;
        {x4, x3, x2, x1} = xv;
        {y4, y3, y2, y1} = yv;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 1'($urandom);
        {x4, x3, x2, x1} = 16'($urandom);
        {y4, y3, y2, y1} = 20'($urandom);

        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1)
                chk("busy_first", int'(busy), 1);
            if (ram_re || ram_we) begin
                acc_addr.push_back(int'(ram_addr));
                acc_cyc.push_back(n);
                acc_we.push_back(ram_we);
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = n;
                    col_at_done = collide;
                    busy_at_done = busy;
                end
            end
            start = dup && ((n == 3 && busy) || done);
        end
        start = 1'b0;

        chk("done_count", done_cnt, 1);
        chk("done_latency", done_at, exp_lat);
        chk("collide_at_done", int'(col_at_done), int'(exp_col));
        chk("busy_at_done", int'(busy_at_done), 1);
        chk("collide_held", int'(collide), int'(exp_col));
        chk("busy_idle", int'(busy), 0);
        chk("access_count", acc_addr.size(), oob ? 0 : 4);
        if (!oob && acc_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("addr%0d", i), acc_addr[i], addrs[i]);
                chk($sformatf("cyc%0d", i), acc_cyc[i], i + 1);
                chk($sformatf("kind%0d", i), int'(acc_we[i]), int'(opv));
            end
        end
        if (opv && !oob)
            for (int i = 0; i < 4; i++)
                ref_board[addrs[i]] = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_collide"}, int'(collide), 0);
        chk({tag, "_re"}, int'(ram_re), 0);
        chk({tag, "_we"}, int'(ram_we), 0);
        chk({tag, "_wdata"}, int'(ram_wdata), 0);
        chk({tag, "_addr"}, int'(ram_addr), 0);
    endtask

    initial begin
        logic [3:0][3:0] xv;
        logic [3:0][4:0] yv;
        bit              opv;
        n_chk = 0;
        n_fail = 0;
        bad_cnt = 0;
        wr_nonzero = 0;
        rdata_q = 1'b0;
        resetn = 1'b0;
        start = 1'b0;
        op = 1'b0;
        {x4, x3, x2, x1} = '0;
        {y4, y3, y2, y1} = '0;
        clear_boards();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        xv = {4'd5, 4'd5, 4'd4, 4'd4};
        yv = {5'd0, 5'd1, 5'd1, 5'd0};
        run_op(1'b0, xv, yv, 1'b0);

        ram[15] = 1'b1;
        ref_board[15] = 1'b1;
        run_op(1'b0, xv, yv, 1'b0);

        xv = {4'd1, 4'd10, 4'd2, 4'd3};
        yv = {5'd2, 5'd2, 5'd2, 5'd2};
        run_op(1'b0, xv, yv, 1'b0);
        xv = {4'd1, 4'd1, 4'd2, 4'd3};
        yv = {5'd20, 5'd2, 5'd2, 5'd2};
        run_op(1'b1, xv, yv, 1'b0);

        xv = {4'd9, 4'd9, 4'd8, 4'd8};
        yv = {5'd18, 5'd19, 5'd19, 5'd18};
        run_op(1'b1, xv, yv, 1'b0);
        run_op(1'b0, xv, yv, 1'b0);

        xv = {4'd0, 4'd1, 4'd2, 4'd3};
        yv = {5'd5, 5'd5, 5'd5, 5'd5};
        run_op(1'b0, xv, yv, 1'b1);
        run_op(1'b1, xv, yv, 1'b1);

        for (int i = 0; i < 256; i++) begin
            ram[i] = ($urandom_range(0, 3) == 0);
            ref_board[i] = ram[i];
        end
        for (int t = 0; t < 60; t++) begin
            opv = 1'($urandom);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) begin
                    xv[b] = 4'($urandom);
                    yv[b] = 5'($urandom);
                end else begin
                    xv[b] = 4'($urandom_range(0, 9));
                    yv[b] = 5'($urandom_range(0, 19));
                end
            end
            run_op(opv, xv, yv, t[2]);
        end

        clear_boards();
        wr_nonzero = 0;
        xv = '0;
        yv = '0;
        @(negedge clk);
        start = 1'b1;
        op = 1'b1;
        {x4, x3, x2, x1} = xv;
        {y4, y3, y2, y1} = yv;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        chk("midreset_nonzero_writes", wr_nonzero, 0);
        chk("midreset_cell0", int'(ram[0]), 1);
        @(negedge clk);
        resetn = 1'b1;
        clear_boards();
        repeat (2) @(negedge clk);

        chk("strobe_rules", bad_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
